pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Consumes the hazard-detection flag, the EXE-stage branch-taken signal and MEM-stage SRAM handshakes.
- Drives per-register freeze, bubble and flush controls plus the SRAM start pulse, so that hazard, branch and memory-wait events are applied with fixed priority.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_stall_controller.sv | 128 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: applies memory-wait, branch flush and
// RAW hazard stalls with fixed priority and keeps saturating stall/flush debug counters.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Hazard_detected,
  input  logic             Branch_taken,
  input  logic             Mem_r_en,
  input  logic             Mem_w_en,
  input  logic             Sram_ready,
  input  logic             Clr_counters,
  output logic             Freeze_PC,
  output logic             Freeze_IF_ID,
  output logic             Freeze_ID_EXE,
  output logic             Freeze_EXE_MEM,
  output logic             Freeze_MEM_WB,
  output logic             Bubble_ID_EXE,
  output logic             Flush_IF_ID,
  output logic             Sram_start,
  output logic             Mem_timeout,
  output logic [CNT_W-1:0] Stall_count,
  output logic [CNT_W-1:0] Flush_count,
  output logic             state_dbg
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          mem_req;
  logic          timeout_hit;
  logic          ready_hit;

  assign mem_req     = Mem_r_en | Mem_w_en;
  assign ready_hit   = (state == MEM_WAIT) && Sram_ready;
  // Sram_ready wins over a same-cycle timeout: the access completed in time.
  assign timeout_hit = (state == MEM_WAIT) && !Sram_ready && (wait_cnt == WAIT_LIMIT);
  assign state_dbg   = (state == MEM_WAIT);

  always_comb begin
    Freeze_PC      = 1'b0;
    Freeze_IF_ID   = 1'b0;
    Freeze_ID_EXE  = 1'b0;
    Freeze_EXE_MEM = 1'b0;
    Freeze_MEM_WB  = 1'b0;
    Bubble_ID_EXE  = 1'b0;
    Flush_IF_ID    = 1'b0;
    Sram_start     = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (mem_req) begin
            Sram_start     = 1'b1;
            Freeze_PC      = 1'b1;
            Freeze_IF_ID   = 1'b1;
            Freeze_ID_EXE  = 1'b1;
            Freeze_EXE_MEM = 1'b1;
            Freeze_MEM_WB  = 1'b1;
          end else if (Branch_taken) begin
            Flush_IF_ID   = 1'b1;
            Bubble_ID_EXE = 1'b1;
          end else if (Hazard_detected) begin
            Freeze_PC     = 1'b1;
            Freeze_IF_ID  = 1'b1;
            Bubble_ID_EXE = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!ready_hit && !timeout_hit) begin
            Freeze_PC      = 1'b1;
            Freeze_IF_ID   = 1'b1;
            Freeze_ID_EXE  = 1'b1;
            Freeze_EXE_MEM = 1'b1;
            Freeze_MEM_WB  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      Mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (ready_hit || timeout_hit) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (timeout_hit) Mem_timeout <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Counters saturate at all-ones; a clear request beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_count <= '0;
      Flush_count <= '0;
    end else if (Clr_counters) begin
      Stall_count <= '0;
      Flush_count <= '0;
    end else begin
      if (Freeze_PC && (Stall_count != {CNT_W{1'b1}})) Stall_count <= Stall_count + 1'b1;
      if (Flush_IF_ID && (Flush_count != {CNT_W{1'b1}})) Flush_count <= Flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed plus randomized bench for pipeline_stall_controller, checked against a
// cycle-level reference model of the stall/flush rules (4-bit counters to reach saturation).
module tb_pipeline_stall_controller;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             Hazard_detected, Branch_taken, Mem_r_en, Mem_w_en, Sram_ready, Clr_counters;
  logic             Freeze_PC, Freeze_IF_ID, Freeze_ID_EXE, Freeze_EXE_MEM, Freeze_MEM_WB;
  logic             Bubble_ID_EXE, Flush_IF_ID, Sram_start, Mem_timeout, state_dbg;
  logic [CNT_W-1:0] Stall_count, Flush_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: access in progress, frozen wait cycles so far, sticky timeout, counters.
  bit m_busy;
  int m_waited;
  bit m_tmo;
  int m_stall;
  int m_flush;

  pipeline_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Hazard_detected(Hazard_detected), .Branch_taken(Branch_taken),
    .Mem_r_en(Mem_r_en), .Mem_w_en(Mem_w_en), .Sram_ready(Sram_ready),
    .Clr_counters(Clr_counters),
    .Freeze_PC(Freeze_PC), .Freeze_IF_ID(Freeze_IF_ID), .Freeze_ID_EXE(Freeze_ID_EXE),
    .Freeze_EXE_MEM(Freeze_EXE_MEM), .Freeze_MEM_WB(Freeze_MEM_WB),
    .Bubble_ID_EXE(Bubble_ID_EXE), .Flush_IF_ID(Flush_IF_ID), .Sram_start(Sram_start),
    .Mem_timeout(Mem_timeout), .Stall_count(Stall_count), .Flush_count(Flush_count),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {24'd0, Freeze_PC, Freeze_IF_ID, Freeze_ID_EXE, Freeze_EXE_MEM, Freeze_MEM_WB,
            Bubble_ID_EXE, Flush_IF_ID, Sram_start};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
  endtask

  // Drive one cycle, compare against the model before the edge, then advance the model.
  task automatic step(input logic hz, input logic br, input logic rd, input logic wr,
                      input logic rdy, input logic clr);
    bit f_pc, f_ifid, f_rest, bub, fl, st, nx_busy, nx_tmo;
    int nx_waited;
    logic [31:0] exp_ctrl;
    Hazard_detected = hz; Branch_taken = br; Mem_r_en = rd; Mem_w_en = wr;
    Sram_ready = rdy; Clr_counters = clr;
    f_pc = 0; f_ifid = 0; f_rest = 0; bub = 0; fl = 0; st = 0;
    nx_busy = m_busy; nx_waited = m_waited; nx_tmo = m_tmo;
    if (!m_busy) begin
      if (rd || wr) begin
        st = 1; f_pc = 1; f_ifid = 1; f_rest = 1; nx_busy = 1; nx_waited = 0;
      end else if (br) begin
        fl = 1; bub = 1;
      end else if (hz) begin
        f_pc = 1; f_ifid = 1; bub = 1;
      end
    end else if (rdy) begin
      nx_busy = 0;
    end else if (m_waited == MEM_TIMEOUT) begin
      nx_busy = 0; nx_tmo = 1;
    end else begin
      f_pc = 1; f_ifid = 1; f_rest = 1; nx_waited = m_waited + 1;
    end
    exp_ctrl = {24'd0, f_pc, f_ifid, f_rest, f_rest, f_rest, bub, fl, st};
    @(negedge clk);
    check("ctrl", ctrl_vec(), exp_ctrl);
    check("state", {31'd0, state_dbg}, {31'd0, m_busy});
    check("stall_cnt", {28'd0, Stall_count}, m_stall);
    check("flush_cnt", {28'd0, Flush_count}, m_flush);
    check("mem_timeout", {31'd0, Mem_timeout}, {31'd0, m_tmo});
    m_busy = nx_busy; m_waited = nx_waited; m_tmo = nx_tmo;
    if (clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (f_pc && m_stall < CNT_MAX) m_stall++;
      if (fl && m_flush < CNT_MAX) m_flush++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    Hazard_detected = 1'b1; Branch_taken = 1'b0; Mem_r_en = 1'b1; Mem_w_en = 1'b0;
    Sram_ready = 1'b0; Clr_counters = 1'b0;
    model_reset();

    // Reset held with hazard and read asserted: all controls low, counters clear.
    repeat (3) @(posedge clk);
    #2;
    check("rst_ctrl", ctrl_vec(), 32'd0);
    check("rst_stall", {28'd0, Stall_count}, 32'd0);
    check("rst_flush", {28'd0, Flush_count}, 32'd0);
    check("rst_tmo", {31'd0, Mem_timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Read still pending after reset: one start pulse, then wait for ready.
    step(1, 0, 1, 0, 0, 0);
    check("post_rst_state", {31'd0, state_dbg}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("no_restart", {31'd0, Sram_start}, 32'd0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);

    // Two hazard cycles: PC and IF/ID held, bubble inserted, back end advances.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(1);
    check("hazard_stall2", {28'd0, Stall_count}, 32'd2);

    // Branch wins over a same-cycle hazard.
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    check("branch_flush1", {28'd0, Flush_count}, 32'd1);
    check("branch_nostall", {28'd0, Stall_count}, 32'd0);

    // Write access: start cycle plus three frozen wait cycles, released on the ready cycle.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1, 0);
    check("write_stall4", {28'd0, Stall_count}, 32'd4);
    check("write_state", {31'd0, state_dbg}, 32'd0);

    // Read with no ready: 16 frozen cycles, sticky timeout, stall counter saturates.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    idle(MEM_TIMEOUT + 1);
    check("tmo_sticky", {31'd0, Mem_timeout}, 32'd1);
    check("stall_sat", {28'd0, Stall_count}, CNT_MAX);
    step(1, 0, 0, 0, 0, 0);
    check("stall_hold", {28'd0, Stall_count}, CNT_MAX);
    step(1, 0, 0, 0, 0, 1);
    check("clr_wins", {28'd0, Stall_count}, 32'd0);
    idle(2);
    check("tmo_held", {31'd0, Mem_timeout}, 32'd1);

    // Randomized traffic; ready arrives no earlier than the second wait cycle.
    for (int i = 0; i < 400; i++) begin
      logic hz, br, rd, wr, rdy, clr;
      hz  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 5) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      wr  = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 40) == 0);
      if (m_busy) rdy = (m_waited >= 1) && ($urandom_range(0, 5) == 0);
      else        rdy = ($urandom_range(0, 6) == 0);
      step(hz, br, rd, wr, rdy, clr);
    end

    // Reset in the middle of an access abandons it without a second start.
    if (m_busy) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    rst_n = 1'b0;
    #2;
    check("midrst_ctrl", ctrl_vec(), 32'd0);
    check("midrst_state", {31'd0, state_dbg}, 32'd0);
    check("midrst_tmo", {31'd0, Mem_timeout}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
